// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Shared definitions for the elevator call panel: floor encodings, the
//   button bit map used by btn_raw/req/lamp, and the per-floor service mask.
package elevator_pkg;

    localparam int NUM_BTN = 7;

    localparam logic [1:0] GROUND_FLR  = 2'b00;
    localparam logic [1:0] FIRST_FLR   = 2'b01;
    localparam logic [1:0] SECOND_FLR  = 2'b10;
    localparam logic [1:0] ILLEGAL_FLR = 2'b11;

    localparam int BTN_G_UP  = 0;
    localparam int BTN_1_UP  = 1;
    localparam int BTN_1_DN  = 2;
    localparam int BTN_2_DN  = 3;
    localparam int BTN_CAR_G = 4;
    localparam int BTN_CAR_1 = 5;
    localparam int BTN_CAR_2 = 6;

    // Requests cleared when the car is serviced at a floor. Hall up and down
    // at the first floor clear together (no direction filtering). The
    // illegal encoding maps to an empty mask so nothing is ever cleared.
    function automatic logic [NUM_BTN-1:0] flr_mask(input logic [1:0] floor);
        logic [NUM_BTN-1:0] m;
        m = '0;
        case (floor)
            GROUND_FLR: begin
                m[BTN_G_UP]  = 1'b1;
                m[BTN_CAR_G] = 1'b1;
            end
            FIRST_FLR: begin
                m[BTN_1_UP]  = 1'b1;
                m[BTN_1_DN]  = 1'b1;
                m[BTN_CAR_1] = 1'b1;
            end
            SECOND_FLR: begin
                m[BTN_2_DN]  = 1'b1;
                m[BTN_CAR_2] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   One button channel: 2-flop synchroniser, saturating debounce counter
//   and rising-edge detect of the debounced state.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     btn_raw     - raw asynchronous button level
//     press       - one-cycle pulse when a debounced press is accepted
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             deb;
    logic             deb_d;

    always_comb begin
        cnt_nxt = '0;
        if (sync_p1) begin
            cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
        end else begin
            // synchroniser stage
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            // debounce stage: state goes high on the same edge the count
            // reaches its limit, and drops as soon as the input drops
            cnt     <= cnt_nxt;
            deb     <= sync_p1 && (cnt_nxt == CNT_MAX);
            deb_d   <= deb;
        end
    end

    // A held button keeps deb high, so only its first cycle is a press.
    assign press = deb && !deb_d;

endmodule

// File: rtl/elevator_call_panel.sv
// elevator_call_panel
//   Front end between the call buttons and the elevator controller.
//   Debounces the 7 buttons, latches presses as pending requests and clears
//   them when the car is stopped with its door open at the matching floor.
//   Ports:
//     clk, rst_n    - clock, asynchronous active-low reset
//     btn_raw[6:0]  - raw buttons (bit map in elevator_pkg)
//     current_flr   - car floor from controller (11 is illegal)
//     is_moving     - car moving
//     is_door_close - door closed
//     req[6:0]      - pending requests
//     lamp[6:0]     - button lamps, identical to req
//     req_any       - OR of req, registered alongside req
//     serviced      - one-cycle pulse when service cleared a pending bit
//     flr_err       - sticky illegal-floor flag
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [1:0]         current_flr,
    input  logic               is_moving,
    input  logic               is_door_close,
    output logic [NUM_BTN-1:0] req,
    output logic [NUM_BTN-1:0] lamp,
    output logic               req_any,
    output logic               serviced,
    output logic               flr_err
);

    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] mask;
    logic [NUM_BTN-1:0] clr;
    logic [NUM_BTN-1:0] req_nxt;
    logic               svc;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[i]),
            .press  (press[i])
        );
    end

    assign svc  = !is_moving && !is_door_close && (current_flr != ILLEGAL_FLR);
    assign mask = flr_mask(current_flr);
    assign clr  = svc ? mask : '0;

    // Clear beats press, so a call for the floor being serviced is absorbed.
    assign req_nxt = (req | press) & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req      <= '0;
            req_any  <= 1'b0;
            serviced <= 1'b0;
            flr_err  <= 1'b0;
        end else begin
            req      <= req_nxt;
            req_any  <= |req_nxt;
            serviced <= |(req & clr);
            flr_err  <= flr_err || (current_flr == ILLEGAL_FLR);
        end
    end

    assign lamp = req;

endmodule

// File: tb/tb_elevator_call_panel.sv
module tb_elevator_call_panel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] btn_raw;
    logic [1:0] current_flr;
    logic       is_moving;
    logic       is_door_close;
    logic [6:0] req;
    logic [6:0] lamp;
    logic       req_any;
    logic       serviced;
    logic       flr_err;

    elevator_call_panel dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .current_flr  (current_flr),
        .is_moving    (is_moving),
        .is_door_close(is_door_close),
        .req          (req),
        .lamp         (lamp),
        .req_any      (req_any),
        .serviced     (serviced),
        .flr_err      (flr_err)
    );

    always #5 clk = ~clk;

    // posedge counter; stimulus acts at posedge+1, monitor samples at negedge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [6:0] req;
        logic       srv;
        logic       ferr;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Push an expectation dc cycles from now, kept sorted by cycle.
    task automatic expect_at(input int dc, input logic [6:0] r, input logic s,
                             input logic f, input string nm);
        exp_t e;
        int   pos;
        e.at = cyc + dc; e.req = r; e.srv = s; e.ferr = f; e.name = nm;
        pos = q.size();
        while (pos > 0 && q[pos-1].at > e.at) pos--;
        q.insert(pos, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops every expectation due in the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].at <= cyc) begin
                e = q.pop_front();
                n_chk++;
                if (req !== e.req) begin
                    n_fail++;
                    $display("FAIL %s req: got %b want %b (cyc %0d)", e.name, req, e.req, cyc);
                end
                n_chk++;
                if (lamp !== e.req) begin
                    n_fail++;
                    $display("FAIL %s lamp: got %b want %b", e.name, lamp, e.req);
                end
                n_chk++;
                if (req_any !== (|e.req)) begin
                    n_fail++;
                    $display("FAIL %s req_any: got %b want %b", e.name, req_any, |e.req);
                end
                n_chk++;
                if (serviced !== e.srv) begin
                    n_fail++;
                    $display("FAIL %s serviced: got %b want %b", e.name, serviced, e.srv);
                end
                n_chk++;
                if (flr_err !== e.ferr) begin
                    n_fail++;
                    $display("FAIL %s flr_err: got %b want %b", e.name, flr_err, e.ferr);
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0; btn_raw = '0; current_flr = 2'b00;
        is_moving = 1'b0; is_door_close = 1'b1;
        step(1);
        expect_at(0, 7'b0000000, 0, 0, "reset");
        step(2);
        rst_n = 1'b1;
        step(2);

        // Hold car-to-first for 20 cycles: latency 7, exactly one press.
        btn_raw[5] = 1'b1;
        expect_at(6,  7'b0000000, 0, 0, "hold5_pre");
        expect_at(7,  7'b0100000, 0, 0, "hold5_lat");
        expect_at(19, 7'b0100000, 0, 0, "hold5_steady");
        step(20);
        // Service at first floor while still holding, then close the door:
        // a single press means the request must not come back.
        current_flr = 2'b01; is_door_close = 1'b0;
        expect_at(1, 7'b0000000, 1, 0, "hold5_clear");
        expect_at(2, 7'b0000000, 0, 0, "hold5_srv_pulse");
        step(2);
        is_door_close = 1'b1; current_flr = 2'b00;
        expect_at(10, 7'b0000000, 0, 0, "hold5_no_repress");
        step(11);
        btn_raw[5] = 1'b0;
        step(4);

        // 3-cycle glitch rejected.
        btn_raw[1] = 1'b1;
        step(3);
        btn_raw[1] = 1'b0;
        expect_at(8, 7'b0000000, 0, 0, "glitch3");
        step(10);

        // 5-cycle pulses on two bits latch together.
        btn_raw[1] = 1'b1; btn_raw[2] = 1'b1;
        expect_at(6, 7'b0000000, 0, 0, "pulse5_pre");
        expect_at(7, 7'b0000110, 0, 0, "pulse5_lat");
        step(5);
        btn_raw[1] = 1'b0; btn_raw[2] = 1'b0;
        step(5);

        // Service at first floor clears both hall bits.
        current_flr = 2'b01; is_door_close = 1'b0;
        expect_at(1, 7'b0000000, 1, 0, "svc1_clear");
        expect_at(2, 7'b0000000, 0, 0, "svc1_pulse_end");
        step(2);

        // Press at ground with door open there: absorbed.
        current_flr = 2'b00;
        btn_raw[0] = 1'b1;
        expect_at(7,  7'b0000000, 0, 0, "absorb_lat");
        expect_at(10, 7'b0000000, 0, 0, "absorb_late");
        step(10);
        btn_raw[0] = 1'b0;
        is_door_close = 1'b1;
        step(4);
        btn_raw[0] = 1'b1;
        expect_at(7, 7'b0000001, 0, 0, "repress0");
        step(8);
        btn_raw[0] = 1'b0;

        // Second-floor hall down pending.
        btn_raw[3] = 1'b1;
        expect_at(7, 7'b0001001, 0, 0, "press3");
        step(8);
        btn_raw[3] = 1'b0;
        step(2);

        // Illegal floor with door open: no clear, sticky error.
        current_flr = 2'b11; is_door_close = 1'b0;
        expect_at(1, 7'b0001001, 0, 1, "illegal_flr");
        step(3);
        current_flr = 2'b10;
        expect_at(1, 7'b0000001, 1, 1, "svc2_after_err");
        expect_at(2, 7'b0000001, 0, 1, "err_sticky");
        step(2);
        current_flr = 2'b00; is_door_close = 1'b1;
        step(2);

        // Fill every request, then reset mid-cycle with car-to-second held.
        btn_raw = 7'b1111111;
        expect_at(7, 7'b1111111, 0, 1, "all_pending");
        step(8);
        btn_raw = 7'b1000000;
        step(2);
        #3;
        rst_n = 1'b0;
        expect_at(0, 7'b0000000, 0, 0, "async_reset");
        step(2);
        rst_n = 1'b1;
        expect_at(6, 7'b0000000, 0, 0, "post_rst_pre");
        expect_at(7, 7'b1000000, 0, 0, "post_rst_lat");
        step(9);
        btn_raw = '0;

        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            step(1);
            guard++;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations still pending, want 0", q.size());
        end
        step(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
